my_test_monitor_axi4_regs: RTL

AXI4-Lite target that generalises the `t_ctrl` control-port monitor into a working register block. It provides `numRegs` byte-strobed read/write scratch registers plus two read-only transaction counters. AW and W are accepted independently and in either order, and out-of-map or read-only writes return SLVERR. Register contents are driven flat on `regs_out` so that test logic in the same design can observe them.

---
 rtl/my_test_monitor_axi4_regs_if.sv | 38 +++
 rtl/my_test_monitor_axi4_regs.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/my_test_monitor_axi4_regs_if.sv
// AXI4-Lite bus bundle for the t_ctrl register port.
// The master drives requests; the slave (register block) drives readies and responses.
interface my_test_monitor_axi4_regs_if #(
    parameter int addrWidth = 32,
    parameter int dataWidth = 32
);
    logic                   awvalid;
    logic                   awready;
    logic [addrWidth-1:0]   awaddr;
    logic [2:0]             awprot;
    logic                   wvalid;
    logic                   wready;
    logic [dataWidth-1:0]   wdata;
    logic [dataWidth/8-1:0] wstrb;
    logic                   bvalid;
    logic                   bready;
    logic [1:0]             bresp;
    logic                   arvalid;
    logic                   arready;
    logic [addrWidth-1:0]   araddr;
    logic [2:0]             arprot;
    logic                   rvalid;
    logic                   rready;
    logic [dataWidth-1:0]   rdata;
    logic [1:0]             rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/my_test_monitor_axi4_regs.sv
// AXI4-Lite register block: numRegs byte-strobed RW scratch registers followed by
// read-only write/read transaction counters. AW and W are captured independently;
// the write commits on the edge where both are available. Registers are exported flat.
module my_test_monitor_axi4_regs #(
    parameter int addrWidth = 32,
    parameter int dataWidth = 32,
    parameter int numRegs   = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    my_test_monitor_axi4_regs_if.slave     t_ctrl,
    output logic [numRegs*dataWidth-1:0]   regs_out
);
    localparam int NB  = dataWidth / 8;
    localparam int LSB = (dataWidth == 64) ? 3 : 2;
    localparam int IW  = addrWidth - LSB;
    localparam logic [IW-1:0] IDX_WR = IW'(numRegs);
    localparam logic [IW-1:0] IDX_RD = IW'(numRegs + 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                 aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [IW-1:0]        awidx_q, awidx_d;
    logic [dataWidth-1:0] wdata_q, wdata_d;
    logic [NB-1:0]        wstrb_q, wstrb_d;
    logic                 bvalid_q, bvalid_d;
    logic [1:0]           bresp_q, bresp_d;
    logic                 rvalid_q, rvalid_d;
    logic [dataWidth-1:0] rdata_q, rdata_d;
    logic [1:0]           rresp_q, rresp_d;
    logic [dataWidth-1:0] wr_count_q, wr_count_d, rd_count_q, rd_count_d;
    logic [dataWidth-1:0] regs_q [numRegs];
    logic [dataWidth-1:0] regs_d [numRegs];

    logic                 aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
    logic [IW-1:0]        wr_idx, rd_idx;
    logic [dataWidth-1:0] wr_data;
    logic [NB-1:0]        wr_strb;

    // Protection bits and sub-word address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = &{1'b0, t_ctrl.awprot, t_ctrl.arprot,
                         t_ctrl.awaddr[LSB-1:0], t_ctrl.araddr[LSB-1:0]};

    assign t_ctrl.awready = !reset && !aw_held_q;
    assign t_ctrl.wready  = !reset && !w_held_q;
    assign t_ctrl.arready = !reset && !rvalid_q;
    assign t_ctrl.bvalid  = bvalid_q;
    assign t_ctrl.bresp   = bresp_q;
    assign t_ctrl.rvalid  = rvalid_q;
    assign t_ctrl.rdata   = rdata_q;
    assign t_ctrl.rresp   = rresp_q;

    // Handshakes and the effective write beat (held copy or the one arriving now).
    always_comb begin
        aw_hs   = t_ctrl.awvalid && t_ctrl.awready;
        w_hs    = t_ctrl.wvalid && t_ctrl.wready;
        b_hs    = bvalid_q && t_ctrl.bready;
        ar_hs   = t_ctrl.arvalid && t_ctrl.arready;
        r_hs    = rvalid_q && t_ctrl.rready;
        commit  = !bvalid_q && (aw_held_q || aw_hs) && (w_held_q || w_hs);
        wr_idx  = aw_held_q ? awidx_q : t_ctrl.awaddr[addrWidth-1:LSB];
        wr_data = w_held_q ? wdata_q : t_ctrl.wdata;
        wr_strb = w_held_q ? wstrb_q : t_ctrl.wstrb;
        rd_idx  = t_ctrl.araddr[addrWidth-1:LSB];
    end

    // Write path: capture AW/W, commit byte lanes, hold B until its handshake.
    always_comb begin
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awidx_d    = awidx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;
        wr_count_d = wr_count_q;
        if (aw_hs) begin
            aw_held_d = 1'b1;
            awidx_d   = t_ctrl.awaddr[addrWidth-1:LSB];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = t_ctrl.wdata;
            wstrb_d  = t_ctrl.wstrb;
        end
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = (wr_idx < IDX_WR) ? RESP_OKAY : RESP_SLVERR;
            for (int k = 0; k < numRegs; k++) begin
                if (wr_idx == IW'(k)) begin
                    for (int b = 0; b < NB; b++) begin
                        if (wr_strb[b]) regs_d[k][8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
            end
        end
        if (b_hs) begin
            aw_held_d  = 1'b0;
            w_held_d   = 1'b0;
            bvalid_d   = 1'b0;
            bresp_d    = RESP_OKAY;
            wr_count_d = wr_count_q + dataWidth'(1);
        end
    end

    // Read path: register the addressed value on AR, hold it until R handshake.
    always_comb begin
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rd_count_d = rd_count_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_OKAY;
            if (rd_idx == IDX_WR) begin
                rdata_d = wr_count_q;
            end else if (rd_idx == IDX_RD) begin
                rdata_d = rd_count_q;
            end else if (rd_idx < IDX_WR) begin
                for (int k = 0; k < numRegs; k++) begin
                    if (rd_idx == IW'(k)) rdata_d = regs_q[k];
                end
            end else begin
                rresp_d = RESP_SLVERR;
            end
        end
        if (r_hs) begin
            rvalid_d   = 1'b0;
            rd_count_d = rd_count_q + dataWidth'(1);
        end
    end

    // State registers with synchronous reset; reset abandons any open transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awidx_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            wr_count_q <= '0;
            rd_count_q <= '0;
            regs_q     <= '{default: '0};
        end else begin
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awidx_q    <= awidx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
            regs_q     <= regs_d;
        end
    end

    // Flatten the register file for observation by neighbouring test logic.
    always_comb begin
        regs_out = '0;
        for (int k = 0; k < numRegs; k++) begin
            regs_out[k*dataWidth +: dataWidth] = regs_q[k];
        end
    end
endmodule
